// File: rtl/uart_pkg.sv
// Shared state types and default timing constants for the host UART command interface.
package uart_pkg;

  localparam int unsigned BAUD_DIV_DEF = 2604;
  localparam int unsigned TIMEOUT_DEF  = 20;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HI_LINE
  } rx_state_t;

  typedef enum logic [1:0] {
    WAIT_HI,
    WAIT_LO,
    HOLD
  } asm_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SHIFT
  } tx_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 transmitter: arms on i_send, captures i_data one cycle later, pulses o_done after stop.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_send,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_done
);

  localparam int unsigned     CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);

  tx_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [9:0]    r_shift, w_shift_nxt;
  logic          r_done, w_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (i_send) w_state_nxt = TX_LOAD;
      end
      TX_LOAD: begin
        // Upstream registers the byte, so it is only valid one cycle after i_send.
        w_shift_nxt = {1'b1, i_data, 1'b0};
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
        w_state_nxt = TX_SHIFT;
      end
      TX_SHIFT: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_nxt = '0;
          if (r_bit == 4'd9) begin
            w_state_nxt = TX_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 4'd1;
            w_shift_nxt = {1'b1, r_shift[9:1]};
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  assign o_tx   = (r_state == TX_SHIFT) ? r_shift[0] : 1'b1;
  assign o_done = r_done;

endmodule

// File: rtl/uart_cmd_if.sv
// Host serial front end: assembles two received 8N1 bytes into a held 16-bit command and
// sends response bytes through uart_tx_core.
module uart_cmd_if
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        resp_sent
);

  localparam int unsigned   CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam int unsigned   TO_CYC    = (TIMEOUT == 0) ? 1 : TIMEOUT * BAUD_DIV;
  localparam int unsigned   TO_W      = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_baud, w_rx_baud_nxt;
  logic [3:0]    r_rx_bit, w_rx_bit_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt;
  logic          w_byte_vld;

  asm_state_t      r_asm_state, w_asm_state_nxt;
  logic [15:0]     r_cmd, w_cmd_nxt;
  logic            r_cmd_rdy, w_cmd_rdy_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_rx_baud   <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_asm_state <= WAIT_HI;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_rx_state  <= w_rx_state_nxt;
      r_rx_baud   <= w_rx_baud_nxt;
      r_rx_bit    <= w_rx_bit_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_asm_state <= w_asm_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_cmd_rdy   <= w_cmd_rdy_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_baud_nxt  = r_rx_baud;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_byte_vld     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_baud_nxt  = '0;
        end
      end
      RX_START: begin
        // Mid-start check rejects short glitches as false starts.
        if (r_rx_baud == BAUD_HALF) begin
          w_rx_baud_nxt  = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_baud_nxt = r_rx_baud + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rx_baud == BAUD_LAST) begin
          w_rx_baud_nxt  = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_bit == 4'd7) w_rx_state_nxt = RX_STOP;
          else                  w_rx_bit_nxt   = r_rx_bit + 4'd1;
        end else begin
          w_rx_baud_nxt = r_rx_baud + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rx_baud == BAUD_LAST) begin
          w_rx_baud_nxt = '0;
          if (r_rx_sync) begin
            w_byte_vld     = 1'b1;
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_state_nxt = RX_WAIT_HI_LINE;
          end
        end else begin
          w_rx_baud_nxt = r_rx_baud + 1'b1;
        end
      end
      RX_WAIT_HI_LINE: begin
        if (r_rx_sync) w_rx_state_nxt = RX_IDLE;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_asm_state_nxt = r_asm_state;
    w_cmd_nxt       = r_cmd;
    w_cmd_rdy_nxt   = r_cmd_rdy;
    w_to_cnt_nxt    = '0;
    case (r_asm_state)
      WAIT_HI: begin
        if (w_byte_vld) begin
          w_cmd_nxt[15:8] = r_rx_shift;
          w_asm_state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (w_byte_vld) begin
          w_cmd_nxt[7:0]  = r_rx_shift;
          w_cmd_rdy_nxt   = 1'b1;
          w_asm_state_nxt = HOLD;
        end else if (TIMEOUT != 0 && r_rx_state == RX_IDLE) begin
          // Gap is measured only while the line shows no frame in progress.
          if (r_to_cnt == TO_LAST) w_asm_state_nxt = WAIT_HI;
          else                     w_to_cnt_nxt    = r_to_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (clr_cmd_rdy) begin
          w_cmd_rdy_nxt   = 1'b0;
          w_asm_state_nxt = WAIT_HI;
        end
      end
      default: w_asm_state_nxt = WAIT_HI;
    endcase
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;

  uart_tx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_send (send_resp),
    .i_data (resp),
    .o_tx   (TX),
    .o_done (resp_sent)
  );

endmodule
